dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_lane_steer.sv | 56 +++++
 rtl/dmem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter slice:
//   - DEFAULT_ADDR_W : default word-address width (256 words)
//   - size_e         : access size encoding on the a_size / b_size ports
//   - state_e        : arbiter FSM state encoding
// ----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DEFAULT_ADDR_W = 8;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

endpackage

// File: rtl/dmem_lane_steer.sv
// ----------------------------------------------------------------------------
// dmem_lane_steer
// Combinational byte-lane logic for a 32-bit little-endian data memory.
// Ports:
//   size          in  2   access size (size_e encoding)
//   lane          in  2   byte address bits [1:0]
//   wdata         in  32  right-aligned store data
//   rdata         in  32  raw word read from memory
//   be            out 4   byte-lane enables for a write of this size/lane
//   wdata_steered out 32  store data replicated onto every candidate lane
//   rdata_ext     out 32  addressed byte/halfword, zero-extended; word as-is
// An illegal size yields all-zero outputs.
// ----------------------------------------------------------------------------
module dmem_lane_steer
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_steered,
    output logic [31:0] rdata_ext
);

    logic [31:0] rdata_shift;

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        be            = 4'b0000;
        wdata_steered = 32'd0;
        rdata_ext     = 32'd0;
        rdata_shift   = rdata >> {lane, 3'b000};

        case (size_e'(size))
            SIZE_BYTE: begin
                be            = 4'b0001 << lane;
                wdata_steered = {4{wdata[7:0]}};
                rdata_ext     = {24'd0, rdata_shift[7:0]};
            end
            SIZE_HALF: begin
                be            = lane[1] ? 4'b1100 : 4'b0011;
                wdata_steered = {2{wdata[15:0]}};
                rdata_ext     = {16'd0, (lane[1] ? rdata[31:16] : rdata[15:0])};
            end
            SIZE_WORD: begin
                be            = 4'b1111;
                wdata_steered = wdata;
                rdata_ext     = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Two-port (A = CPU load/store, B = debug/loader) round-robin arbiter in
// front of a single-ported, 1-cycle-latency word memory. Each transaction
// walks IDLE -> ISSUE -> RESP; all outputs are registered.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   x_req/we/size/addr/wdata    request from port x (x = a, b), held to done
//   x_done                      one-cycle completion pulse
//   x_err                       illegal size, misaligned or out of range
//   x_rdata                     zero-extended load data, held between dones
//   mem_en/we/addr/be/wdata     memory strobe, write enable, word address,
//                               byte lanes, lane-steered write data
//   mem_rdata                   memory read data, valid cycle after mem_en
// ----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [1:0]        a_size,
    input  logic [31:0]       a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_done,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [1:0]        b_size,
    input  logic [31:0]       b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_done,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Size/alignment/range legality of one request.
    function automatic logic is_legal(input logic [1:0] size, input logic [31:0] addr);
        logic ok;
        case (size_e'(size))
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~addr[0];
            SIZE_WORD: ok = (addr[1:0] == 2'b00);
            default:   ok = 1'b0;
        endcase
        if ((addr >> (ADDR_W + 2)) != 32'd0) ok = 1'b0;
        return ok;
    endfunction

    state_e      state;
    logic        last_b;      // 1: B was granted last, so A wins a tie

    // Transaction captured on IDLE->ISSUE, used to complete it in RESP.
    logic        txn_b;
    logic        txn_we;
    logic        txn_err;
    logic [1:0]  txn_size;
    logic [1:0]  txn_lane;

    // Winner selection and request mux (only meaningful in IDLE).
    logic        grant_b;
    logic        win_we;
    logic [1:0]  win_size;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        win_legal;

    assign grant_b   = b_req && (!a_req || !last_b);
    assign win_we    = grant_b ? b_we    : a_we;
    assign win_size  = grant_b ? b_size  : a_size;
    assign win_addr  = grant_b ? b_addr  : a_addr;
    assign win_wdata = grant_b ? b_wdata : a_wdata;
    assign win_legal = is_legal(win_size, win_addr);

    // One steering block serves both phases: in IDLE it steers the winner's
    // store data; in RESP it extracts read data using the captured size/lane.
    logic [1:0]  steer_size;
    logic [1:0]  steer_lane;
    logic [3:0]  steer_be;
    logic [31:0] steer_wdata;
    logic [31:0] steer_rdata;

    assign steer_size = (state == ST_IDLE) ? win_size      : txn_size;
    assign steer_lane = (state == ST_IDLE) ? win_addr[1:0] : txn_lane;

    dmem_lane_steer u_lane_steer (
        .size          (steer_size),
        .lane          (steer_lane),
        .wdata         (win_wdata),
        .rdata         (mem_rdata),
        .be            (steer_be),
        .wdata_steered (steer_wdata),
        .rdata_ext     (steer_rdata)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            last_b    <= 1'b1;
            txn_b     <= 1'b0;
            txn_we    <= 1'b0;
            txn_err   <= 1'b0;
            txn_size  <= 2'b00;
            txn_lane  <= 2'b00;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            a_done    <= 1'b0;
            a_err     <= 1'b0;
            a_rdata   <= '0;
            b_done    <= 1'b0;
            b_err     <= 1'b0;
            b_rdata   <= '0;
        end else begin
            a_done <= 1'b0;
            b_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (a_req || b_req) begin
                        state     <= ST_ISSUE;
                        last_b    <= grant_b;
                        txn_b     <= grant_b;
                        txn_we    <= win_we;
                        txn_err   <= ~win_legal;
                        txn_size  <= win_size;
                        txn_lane  <= win_addr[1:0];
                        mem_en    <= win_legal;
                        mem_we    <= win_legal && win_we;
                        mem_be    <= (win_legal && win_we) ? steer_be : 4'b0000;
                        mem_addr  <= win_addr[ADDR_W+1:2];
                        mem_wdata <= steer_wdata;
                    end
                end

                ST_ISSUE: begin
                    state  <= ST_RESP;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    mem_be <= 4'b0000;
                end

                ST_RESP: begin
                    state <= ST_IDLE;
                    // Only legal reads replace the load data; errors and
                    // stores leave the last load result visible.
                    if (txn_b) begin
                        b_done <= 1'b1;
                        b_err  <= txn_err;
                        if (!txn_err && !txn_we) b_rdata <= steer_rdata;
                    end else begin
                        a_done <= 1'b1;
                        a_err  <= txn_err;
                        if (!txn_err && !txn_we) a_rdata <= steer_rdata;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed self-checking bench for dmem_arbiter. Inputs change and outputs
// are sampled 1 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [1:0]  a_size, b_size;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_done, a_err, b_done, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    int n_total = 0;
    int n_pass  = 0;

    dmem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_size    (a_size),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_done    (a_done),
        .a_err     (a_err),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_size    (b_size),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_done    (b_done),
        .b_err     (b_err),
        .b_rdata   (b_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    initial begin
        rst_n = 1'b1;
        a_req = 0; a_we = 0; a_size = 2'b00; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_size = 2'b00; b_addr = 0; b_wdata = 0;
        mem_rdata = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        // Reset values
        check("rst_mem_en",  {31'd0, mem_en},  32'd0);
        check("rst_mem_we",  {31'd0, mem_we},  32'd0);
        check("rst_mem_be",  {28'd0, mem_be},  32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_a_done",  {31'd0, a_done},  32'd0);
        check("rst_b_done",  {31'd0, b_done},  32'd0);
        check("rst_a_err",   {31'd0, a_err},   32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_b_rdata", b_rdata, 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // A byte write 0x5 / 0xAB
        a_req = 1; a_we = 1; a_size = 2'b00; a_addr = 32'h5; a_wdata = 32'hAB;
        tick();                                   // IDLE -> ISSUE
        a_addr = 32'h0000_0008; a_wdata = 32'h5555_5555;  // must not matter
        check("bw_mem_en",    {31'd0, mem_en}, 32'd1);
        check("bw_mem_we",    {31'd0, mem_we}, 32'd1);
        check("bw_mem_addr",  {24'd0, mem_addr}, 32'd1);
        check("bw_mem_be",    {28'd0, mem_be}, 32'b0010);
        check("bw_mem_wdata", mem_wdata, 32'hABAB_ABAB);
        tick();                                   // ISSUE -> RESP
        check("bw_en_off",    {31'd0, mem_en}, 32'd0);
        check("bw_done_early", {31'd0, a_done}, 32'd0);
        tick();                                   // RESP -> IDLE
        check("bw_a_done",    {31'd0, a_done}, 32'd1);
        check("bw_a_err",     {31'd0, a_err},  32'd0);
        check("bw_b_done",    {31'd0, b_done}, 32'd0);
        a_req = 0;
        tick();
        check("bw_done_pulse", {31'd0, a_done}, 32'd0);

        // A halfword write 0x2 / 0xBEEF -> upper half lanes
        a_req = 1; a_we = 1; a_size = 2'b01; a_addr = 32'h2; a_wdata = 32'h0000_BEEF;
        tick();
        check("hw_mem_be",    {28'd0, mem_be}, 32'b1100);
        check("hw_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
        check("hw_mem_addr",  {24'd0, mem_addr}, 32'd0);
        tick(); tick();
        check("hw_a_done",    {31'd0, a_done}, 32'd1);
        a_req = 0;
        tick();

        // A byte read 0x7 -> byte lane 3 of 0x1234ABCD
        mem_rdata = 32'h1234_ABCD;
        a_req = 1; a_we = 0; a_size = 2'b00; a_addr = 32'h7;
        tick();
        check("br_mem_en",  {31'd0, mem_en}, 32'd1);
        check("br_mem_we",  {31'd0, mem_we}, 32'd0);
        check("br_mem_be",  {28'd0, mem_be}, 32'd0);
        tick(); tick();
        check("br_a_done",  {31'd0, a_done}, 32'd1);
        check("br_a_rdata", a_rdata, 32'h0000_0012);
        a_req = 0;
        tick();

        // B halfword read 0xE -> upper half
        b_req = 1; b_we = 0; b_size = 2'b01; b_addr = 32'hE;
        tick();
        check("bhr_mem_en",   {31'd0, mem_en}, 32'd1);
        check("bhr_mem_addr", {24'd0, mem_addr}, 32'd3);
        tick(); tick();
        check("bhr_b_done",   {31'd0, b_done}, 32'd1);
        check("bhr_b_rdata",  b_rdata, 32'h0000_1234);
        check("bhr_b_err",    {31'd0, b_err}, 32'd0);
        check("bhr_a_done",   {31'd0, a_done}, 32'd0);
        check("bhr_a_rdata",  a_rdata, 32'h0000_0012);
        b_req = 0;
        tick();

        // A misaligned word write 0x402: no memory access, error
        mem_rdata = 32'hFFFF_FFFF;
        a_req = 1; a_we = 1; a_size = 2'b10; a_addr = 32'h402; a_wdata = 32'h1111_1111;
        tick();
        check("mis_mem_en", {31'd0, mem_en}, 32'd0);
        check("mis_mem_we", {31'd0, mem_we}, 32'd0);
        check("mis_mem_be", {28'd0, mem_be}, 32'd0);
        tick();
        check("mis_mem_en2", {31'd0, mem_en}, 32'd0);
        tick();
        check("mis_a_done", {31'd0, a_done}, 32'd1);
        check("mis_a_err",  {31'd0, a_err},  32'd1);
        a_req = 0;
        tick();

        // A out-of-range word read 0x400: error, rdata unchanged
        a_req = 1; a_we = 0; a_size = 2'b10; a_addr = 32'h400;
        tick();
        check("oor_mem_en", {31'd0, mem_en}, 32'd0);
        tick(); tick();
        check("oor_a_done",  {31'd0, a_done}, 32'd1);
        check("oor_a_err",   {31'd0, a_err},  32'd1);
        check("oor_a_rdata", a_rdata, 32'h0000_0012);
        a_req = 0;
        tick();

        // Illegal size 11 at an aligned in-range address
        a_req = 1; a_we = 0; a_size = 2'b11; a_addr = 32'h0;
        tick();
        check("ill_mem_en", {31'd0, mem_en}, 32'd0);
        tick(); tick();
        check("ill_a_err",  {31'd0, a_err}, 32'd1);
        a_req = 0;
        tick();

        // Round robin from reset: A, B, A, B with both held
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        a_req = 1; a_we = 0; a_size = 2'b10; a_addr = 32'h10;   // word 4
        b_req = 1; b_we = 0; b_size = 2'b10; b_addr = 32'h20;   // word 8
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr%0d_mem_addr", k), {24'd0, mem_addr}, (k % 2 == 0) ? 32'd4 : 32'd8);
            tick(); tick();
            check($sformatf("rr%0d_a_done", k), {31'd0, a_done}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d_b_done", k), {31'd0, b_done}, (k % 2 == 0) ? 32'd0 : 32'd1);
        end
        check("rr_a_rdata", a_rdata, 32'hCAFE_F00D);
        a_req = 0; b_req = 0;
        tick();

        // Reset during ISSUE aborts; A regains priority afterwards
        b_req = 1;
        tick();
        check("ab_mem_en", {31'd0, mem_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ab_mem_en_rst",   {31'd0, mem_en}, 32'd0);
        check("ab_mem_addr_rst", {24'd0, mem_addr}, 32'd0);
        check("ab_a_rdata_rst",  a_rdata, 32'd0);
        check("ab_b_rdata_rst",  b_rdata, 32'd0);
        b_req = 0;
        tick();
        rst_n = 1'b1;
        tick();
        check("ab_no_b_done", {31'd0, b_done}, 32'd0);
        tick();
        check("ab_no_b_done2", {31'd0, b_done}, 32'd0);
        check("ab_mem_en_idle", {31'd0, mem_en}, 32'd0);
        a_req = 1; b_req = 1;
        tick();
        check("ab_a_first", {24'd0, mem_addr}, 32'd4);
        tick(); tick();
        check("ab_a_done", {31'd0, a_done}, 32'd1);
        check("ab_b_idle", {31'd0, b_done}, 32'd0);
        a_req = 0; b_req = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
